// File: rtl/rca_shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// Contents: FSM state type, adder width, and the iteration-counter width helper.
package rca_shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int ADDER_W = 64;

    // Counter must hold 0..WIDTH-1 with one spare bit.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/rca_shift_add_mult_if.sv
// Request/result bundle for the shift-and-add multiplier.
// master: drives start/a/b, observes busy/done/product/ovf.
// slave : the multiplier side.
interface rca_shift_add_mult_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic               ovf;

    modport master (output start, a, b, input busy, done, product, ovf);
    modport slave  (input start, a, b, output busy, done, product, ovf);
endinterface

// File: rtl/rca_shift_add_mult_rca.sv
// 64-bit ripple-carry adder.
// Ports: a, b (addends), c_in (carry in), s (sum), c_out (carry out).
module RCA_64_bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c_in,
    output logic [63:0] s,
    output logic        c_out
);
    always_comb begin
        logic carry;
        carry = c_in;
        s     = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end
endmodule

// File: rtl/rca_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier; one adder pass per cycle.
// Ports: clk, rst_n (async active-low), bus (slave modport):
//   start/a/b in, busy (RUN), done (1-cycle pulse), product (held), ovf (sticky).
module rca_shift_add_mult
    import rca_shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rca_shift_add_mult_if.slave  bus
);
    localparam int CW = cnt_w(WIDTH);

    state_t               state_q, state_d;
    logic [ADDER_W-1:0]   mcand_q, mcand_d;
    logic [ADDER_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovf_q, ovf_d;

    logic [ADDER_W-1:0]   add_b;
    logic [ADDER_W-1:0]   sum;
    logic                 c_out;

    assign add_b = mplier_q[0] ? mcand_q : '0;

    RCA_64_bit u_adder (
        .a     (acc_q),
        .b     (add_b),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{(ADDER_W-WIDTH){1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (c_out) ovf_d = 1'b1;
                // Product is taken from the final sum so it is already
                // registered when done rises.
                if (count_q == CW'(WIDTH-1)) begin
                    product_d = sum[2*WIDTH-1:0];
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_rca_shift_add_mult.sv
// Self-checking bench for rca_shift_add_mult: directed cases plus random
// operands on a 32-bit and an 8-bit instance, checked against a*b.
module tb_rca_shift_add_mult;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    rca_shift_add_mult_if #(.WIDTH(32)) bus32 ();
    rca_shift_add_mult_if #(.WIDTH(8))  bus8 ();

    rca_shift_add_mult #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    rca_shift_add_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input bit w8);
        return w8 ? bus8.done : bus32.done;
    endfunction
    function automatic logic busy_of(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction
    function automatic logic ovf_of(input bit w8);
        return w8 ? bus8.ovf : bus32.ovf;
    endfunction
    function automatic logic [63:0] prod_of(input bit w8);
        return w8 ? 64'(bus8.product) : bus32.product;
    endfunction
    function automatic logic cout_of(input bit w8);
        return w8 ? dut8.u_adder.c_out : dut32.u_adder.c_out;
    endfunction

    task automatic drive(input bit w8, input logic st, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.start = st; bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus32.start = st; bus32.a = a; bus32.b = b;
        end
    endtask

    // Called just after the accepting edge; walks until done, scrambling the
    // operand inputs every cycle (they must be ignored while running).
    task automatic wait_done(input bit w8, output int edges, output int bcnt, output int ccnt);
        edges = 0; bcnt = 0; ccnt = 0;
        while (!done_of(w8) && edges < 200) begin
            if (busy_of(w8)) begin
                bcnt++;
                if (cout_of(w8)) ccnt++;
            end
            @(posedge clk); #1;
            edges++;
            if (!done_of(w8)) drive(w8, 1'b0, $urandom, $urandom);
        end
        check("done_seen", 64'(done_of(w8)), 64'd1);
    endtask

    task automatic run_mul(input bit w8, input logic [31:0] a, input logic [31:0] b);
        int w = w8 ? 8 : 32;
        logic [63:0] exp, prev;
        int edges, bcnt, ccnt;
        exp  = w8 ? 64'(a[7:0]) * 64'(b[7:0]) : 64'(a) * 64'(b);
        @(posedge clk); #1;
        prev = prod_of(w8);
        drive(w8, 1'b1, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, a, b);
        check("busy_after_start", 64'(busy_of(w8)), 64'd1);
        check("product_held_at_start", prod_of(w8), prev);
        wait_done(w8, edges, bcnt, ccnt);
        check("latency_edges", 64'(edges + 1), 64'(w + 1));
        check("busy_cycles", 64'(bcnt), 64'(w));
        check("adder_cout", 64'(ccnt), 64'd0);
        check("product", prod_of(w8), exp);
        check("ovf", 64'(ovf_of(w8)), 64'd0);
        @(posedge clk); #1;
        check("done_single_pulse", 64'(done_of(w8)), 64'd0);
        check("idle_after_done", 64'(busy_of(w8)), 64'd0);
        check("product_hold_idle", prod_of(w8), exp);
    endtask

    initial begin
        int edges, bcnt, ccnt, dcount;
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus32.busy), 64'd0);
        check("reset_done", 64'(bus32.done), 64'd0);
        check("reset_product", bus32.product, 64'd0);
        check("reset_ovf", 64'(bus32.ovf), 64'd0);
        rst_n = 1'b1;

        run_mul(1'b0, 32'd0, 32'hFFFF_FFFF);
        run_mul(1'b0, 32'd84935, 32'd98765);
        check("known_product", bus32.product, 64'd8388605275);
        run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max_product", bus32.product, 64'hFFFF_FFFE_0000_0001);

        // Start re-pulsed mid-run must be ignored.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'd3, 32'd5);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd3, 32'd5);
        repeat (10) begin @(posedge clk); #1; end
        drive(1'b0, 1'b1, 32'd7, 32'd7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd7, 32'd7);
        wait_done(1'b0, edges, bcnt, ccnt);
        check("latency_restart_ignored", 64'(edges + 11 + 1), 64'd33);
        check("product_restart_ignored", bus32.product, 64'd15);
        // New start in the IDLE cycle right after DONE is accepted.
        @(posedge clk); #1;
        check("no_second_done", 64'(bus32.done), 64'd0);
        drive(1'b0, 1'b1, 32'd6, 32'd9);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        check("back_to_back_accept", 64'(bus32.busy), 64'd1);
        wait_done(1'b0, edges, bcnt, ccnt);
        check("back_to_back_product", bus32.product, 64'd54);

        // Reset mid-run aborts without a done pulse.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'd1234, 32'd5678);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (20) begin @(posedge clk); #1; end
        check("busy_before_abort", 64'(bus32.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus32.busy), 64'd0);
        check("abort_done", 64'(bus32.done), 64'd0);
        check("abort_product", bus32.product, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.done) dcount++;
        end
        check("no_done_after_abort", 64'(dcount), 64'd0);
        run_mul(1'b0, 32'd2, 32'd3);

        run_mul(1'b1, 32'hFF, 32'hFF);
        check("w8_max_product", 64'(bus8.product), 64'hFE01);

        for (int i = 0; i < 6; i++) run_mul(1'b0, $urandom, $urandom);
        for (int i = 0; i < 6; i++) run_mul(1'b1, $urandom, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rca_shift_add_mult.md
Name: rca_shift_add_mult

Overview:
Sequential unsigned shift-and-add multiplier built on the team's 64-bit ripple-carry adder.
- Adder is instantiated once and reused every cycle as the accumulate stage.
- Takes two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product after a fixed number of cycles.
- Sits downstream of the adder and consumes its sum/carry each cycle; serves as the datapath multiply unit for the arithmetic test harness.

Parameters:
WIDTH, 32, operand width; legal range 1..32 so that 2*WIDTH fits the 64-bit adder.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand, captured on accepted start
b  input  WIDTH  multiplier, captured on accepted start
busy  output  1  high in RUN state
done  output  1  one-cycle pulse when product is valid
product  output  2*WIDTH  result; held stable until the next accepted start
ovf  output  1  sticky error flag: adder c_out was seen high during RUN; cleared on accepted start

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, product=0, ovf=0, count=0, internal registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch mcand = zero-extend(a) to 64 bits and mplier = b; acc=0; count=0; ovf=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - Adder inputs: a = acc, b = mcand when mplier[0]=1, else 64'd0; c_in = 0.
  - Updates: acc <= adder s; mcand <= mcand << 1; mplier <= mplier >> 1; count <= count+1.
  - If adder c_out=1, set ovf. This is unreachable for legal operands; its purpose is as a bench check.
  - When count = WIDTH-1 (the last iteration), go to DONE.
  - RUN lasts exactly WIDTH cycles. There is no early exit when mplier becomes zero, so latency is deterministic.
- DONE:
  - done=1 for exactly one cycle; product = acc[2*WIDTH-1:0] is registered on entry to DONE.
  - Go to IDLE unconditionally.
  - start during DONE is ignored.
- Latency: start sampled at edge E0 -> busy high from E0 through E(WIDTH) -> done high in the cycle after edge E(WIDTH) (WIDTH+1 edges after start) -> back in IDLE one cycle later.
- Minimum start-to-start spacing: WIDTH+2 cycles.
- start while busy or in DONE is ignored, with no queuing; operand changes during RUN have no effect.
- product and ovf hold their values across IDLE until the next accepted start; product is not cleared at start.
- Reset asserted mid-RUN: abort immediately, all outputs to reset values, and no done pulse.
- Counter width: clog2(WIDTH)+1 bits; there is no wrap-around in legal operation.
- Arithmetic: purely unsigned; the upper 64-2*WIDTH bits of acc are always 0.

Decomposition:
- Shared package (e.g. arith_pkg): state enum {IDLE, RUN, DONE}, ADDER_W=64 constant, and the count-width function.
- Sub-module: the existing 64-bit ripple-carry adder RCA_64_bit (ports a, b, c_in, s, c_out), instantiated once and unmodified.
- Everything else is inline: FSM, shift registers, accumulator.

Test Plan:
- Reset then a=0, b=0xFFFFFFFF, start -> done after exactly 33 edges, product=0, ovf=0; busy high for 32 cycles.
- a=84935, b=98765 -> product=64'd8388605275, single-cycle done pulse, ovf=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=64'hFFFFFFFE00000001, ovf=0; bench checks adder c_out=0 every RUN cycle.
- Start accepted with a=3, b=5; start re-pulsed with a=7, b=7 at RUN cycle 10 -> product=15 and no second done; a new start 1 cycle after the DONE cycle -> accepted.
- a=1234, b=5678, rst_n low at RUN cycle 20 -> busy=0, done=0, product=0 asynchronously, with no done pulse after release. A fresh a=2, b=3 -> product=6.
- WIDTH=8 instance: a=8'hFF, b=8'hFF -> product=16'hFE01 after 9 edges.
